qp_wqe_scheduler: RTL and testbench

- Sequences work-queue entries (WQEs) out of the Send and Receive work-queue FIFOs and programs the PCIe DMA descriptor controllers (DCS).
- Sits between the queue-pair block and the DMA engine.
- Arbitrates round-robin between SQ and RQ, pops one 116-bit WQE, and decodes it.
- Issues a fixed four-write Avalon-MM sequence to the read DCS (SQ WQEs) or the write DCS (RQ WQEs).

---
 rtl/qp_sched_pkg.sv | 73 +++++++
 rtl/qp_rr_arb2.sv | 45 ++++
 rtl/qp_wqe_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_qp_wqe_scheduler.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qp_sched_pkg.sv
// ---------------------------------------------------------------------------
// qp_sched_pkg
// Shared definitions for the queue-pair WQE scheduler:
//   - scheduler FSM state encoding
//   - bit positions of the 116-bit WQE fields
//   - DCS register offsets and DCS target encodings
//   - helper functions for WQE validity and total transfer length
// ---------------------------------------------------------------------------
package qp_sched_pkg;

   localparam int WQE_W = 116;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      POP  = 3'd1,
      CAPT = 3'd2,
      WR0  = 3'd3,
      WR1  = 3'd4,
      WR2  = 3'd5,
      WR3  = 3'd6
   } state_t;

   // WQE field bit positions (MSB first)
   localparam int OPC_HI  = 115;
   localparam int OPC_LO  = 111;
   localparam int DN_HI   = 110;
   localparam int DN_LO   = 108;
   localparam int TID_HI  = 107;
   localparam int TID_LO  = 100;
   localparam int LEN0_HI = 99;
   localparam int LEN0_LO = 91;
   localparam int LEN1_HI = 90;
   localparam int LEN1_LO = 82;
   localparam int LEN2_HI = 81;
   localparam int LEN2_LO = 73;
   localparam int LEN3_HI = 72;
   localparam int LEN3_LO = 64;
   localparam int TBL_HI  = 63;
   localparam int TBL_LO  = 0;

   // DCS register offsets
   localparam logic [7:0] DCS_OFS_ADDR_LO  = 8'h00;
   localparam logic [7:0] DCS_OFS_ADDR_HI  = 8'h04;
   localparam logic [7:0] DCS_OFS_CTRL     = 8'h08;
   localparam logic [7:0] DCS_OFS_DOORBELL = 8'h0C;

   // DCS target encodings
   localparam logic DCS_RD = 1'b0;   // read DCS, serves SQ WQEs
   localparam logic DCS_WR = 1'b1;   // write DCS, serves RQ WQEs

   // Grant bit positions of the two-requester arbiter
   localparam int GNT_SQ = 0;
   localparam int GNT_RQ = 1;

   // A WQE carries between one and four data segments.
   function automatic logic wqe_dn_valid(input logic [2:0] dn);
      return (dn != 3'd0) && (dn <= 3'd4);
   endfunction

   // Sum of the first dataNum segment lengths; 4 x 511 fits in 11 bits.
   function automatic logic [10:0] wqe_total_len(input logic [WQE_W-1:0] wqe);
      logic [2:0]  dn;
      logic [10:0] sum;
      dn  = wqe[DN_HI:DN_LO];
      sum = 11'd0;
      sum = sum + ((dn >= 3'd1) ? {2'b00, wqe[LEN0_HI:LEN0_LO]} : 11'd0);
      sum = sum + ((dn >= 3'd2) ? {2'b00, wqe[LEN1_HI:LEN1_LO]} : 11'd0);
      sum = sum + ((dn >= 3'd3) ? {2'b00, wqe[LEN2_HI:LEN2_LO]} : 11'd0);
      sum = sum + ((dn >= 3'd4) ? {2'b00, wqe[LEN3_HI:LEN3_LO]} : 11'd0);
      return sum;
   endfunction

endpackage

// File: rtl/qp_rr_arb2.sv
// ---------------------------------------------------------------------------
// qp_rr_arb2
// Two-requester round-robin arbiter. Bit 0 is the SQ, bit 1 the RQ.
// The last-grant register resets to RQ so that the SQ wins the first tie.
// Ports:
//   clock  in   core clock
//   reset  in   asynchronous active-low reset
//   req    in   [1:0] request vector
//   gnt    out  [1:0] one-hot grant (zero when nothing requests)
// ---------------------------------------------------------------------------
module qp_rr_arb2
   import qp_sched_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_rq_r;   // 1: RQ was granted last, 0: SQ was granted last

   // Grant selection: on a tie, favour the queue not granted last
   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         gnt = last_rq_r ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

   // Last-grant history, updated on every grant
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_rq_r <= 1'b1;
      end else if (gnt[GNT_SQ]) begin
         last_rq_r <= 1'b0;
      end else if (gnt[GNT_RQ]) begin
         last_rq_r <= 1'b1;
      end else begin
         last_rq_r <= last_rq_r;
      end
   end

endmodule

// File: rtl/qp_wqe_scheduler.sv
// ---------------------------------------------------------------------------
// qp_wqe_scheduler
// Pulls WQEs from the Send and Receive work-queue FIFOs (round-robin), decodes
// them and programs the read DCS (SQ) or write DCS (RQ) with a fixed sequence
// of four Avalon-MM writes: table address low/high, control word, doorbell.
// Malformed WQEs (dataNum not 1..4) are dropped and counted.
// Ports:
//   clock, reset              core clock, asynchronous active-low reset
//   enable                    allow new WQEs to be started
//   SqEmpty/SqData/SqPop      SQ FIFO (data valid the cycle after the pop)
//   RqEmpty/RqData/RqPop      RQ FIFO (data valid the cycle after the pop)
//   Dcs*                      Avalon-MM master toward the DCS blocks
//   busy                      high whenever the FSM is not IDLE
//   sqIssued/rqIssued         wrapping counts of fully issued WQEs
//   errCount                  saturating count of dropped WQEs
// ---------------------------------------------------------------------------
module qp_wqe_scheduler
   import qp_sched_pkg::*;
#(
   parameter int NUM_WR = 4,
   parameter int CNT_W  = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic               SqEmpty,
   input  logic [WQE_W-1:0]   SqData,
   output logic               SqPop,
   input  logic               RqEmpty,
   input  logic [WQE_W-1:0]   RqData,
   output logic               RqPop,
   output logic               DcsChipSelect,
   output logic               DcsWrite,
   output logic               DcsTarget,
   output logic [7:0]         DcsAddress,
   output logic [31:0]        DcsWriteData,
   output logic [3:0]         DcsByteEnable,
   input  logic               DcsWaitRequest,
   output logic               busy,
   output logic [CNT_W-1:0]   sqIssued,
   output logic [CNT_W-1:0]   rqIssued,
   output logic [7:0]         errCount
);

   // The write sequence is hard-wired to four registers.
   generate
      if (NUM_WR != 4) begin : g_num_wr_check
         $error("qp_wqe_scheduler supports NUM_WR = 4 only");
      end
   endgenerate

   state_t             state_r;
   state_t             state_s;
   logic [1:0]         req_s;
   logic [1:0]         gnt_s;
   logic               accept_s;
   logic [WQE_W-1:0]   cur_data_s;
   logic [WQE_W-1:0]   wqe_s;
   logic               valid_s;
   logic [10:0]        capt_len_s;
   logic [WQE_W-1:0]   wqe_r;
   logic [10:0]        tot_len_r;

   // registered outputs and their next values
   logic               sq_pop_r,  sq_pop_s;
   logic               rq_pop_r,  rq_pop_s;
   logic               cs_r,      cs_s;
   logic               tgt_r,     tgt_s;
   logic [7:0]         addr_r,    addr_s;
   logic [31:0]        wdata_r,   wdata_s;
   logic               busy_r;
   logic [CNT_W-1:0]   sq_cnt_r;
   logic [CNT_W-1:0]   rq_cnt_r;
   logic [7:0]         err_r;

   // Only an idle scheduler requests; the arbiter history then moves only on
   // grants that are actually taken.
   assign req_s = (state_r == IDLE) ? {~RqEmpty & enable, ~SqEmpty & enable} : 2'b00;

   qp_rr_arb2 u_arb (
      .clock (clock),
      .reset (reset),
      .req   (req_s),
      .gnt   (gnt_s)
   );

   // cs_r is set exactly in the WRn states, so this is "write accepted now".
   assign accept_s   = cs_r & ~DcsWaitRequest;

   // In CAPT the FIFO head is live; afterwards the captured copy is used.
   assign cur_data_s = (tgt_r == DCS_WR) ? RqData : SqData;
   assign wqe_s      = (state_r == CAPT) ? cur_data_s : wqe_r;
   assign valid_s    = wqe_dn_valid(wqe_s[DN_HI:DN_LO]);
   assign capt_len_s = wqe_total_len(wqe_s);

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    state_s = (gnt_s != 2'b00) ? POP : IDLE;
         POP:     state_s = CAPT;
         CAPT:    state_s = valid_s ? WR0 : IDLE;
         WR0:     state_s = accept_s ? WR1 : WR0;
         WR1:     state_s = accept_s ? WR2 : WR1;
         WR2:     state_s = accept_s ? WR3 : WR2;
         WR3:     state_s = accept_s ? IDLE : WR3;
         default: state_s = IDLE;
      endcase
   end

   // Next output values, derived from the state being entered so that the
   // outputs can be registered without adding latency.
   always_comb begin
      sq_pop_s = 1'b0;
      rq_pop_s = 1'b0;
      cs_s     = 1'b0;
      tgt_s    = tgt_r;
      addr_s   = 8'h00;
      wdata_s  = 32'h0000_0000;
      case (state_s)
         POP: begin
            sq_pop_s = gnt_s[GNT_SQ];
            rq_pop_s = gnt_s[GNT_RQ];
            tgt_s    = gnt_s[GNT_RQ] ? DCS_WR : DCS_RD;
         end
         WR0: begin
            cs_s    = 1'b1;
            addr_s  = DCS_OFS_ADDR_LO;
            wdata_s = wqe_s[31:0];
         end
         WR1: begin
            cs_s    = 1'b1;
            addr_s  = DCS_OFS_ADDR_HI;
            wdata_s = wqe_s[TBL_HI:32];
         end
         WR2: begin
            cs_s    = 1'b1;
            addr_s  = DCS_OFS_CTRL;
            wdata_s = {wqe_s[OPC_HI:OPC_LO], wqe_s[DN_HI:DN_LO],
                       wqe_s[TID_HI:TID_LO], 5'd0, tot_len_r};
         end
         WR3: begin
            cs_s    = 1'b1;
            addr_s  = DCS_OFS_DOORBELL;
            wdata_s = {24'd0, wqe_s[TID_HI:TID_LO]};
         end
         default: begin
            cs_s    = 1'b0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // WQE capture and total-length register, loaded once per WQE in CAPT
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wqe_r     <= {WQE_W{1'b0}};
         tot_len_r <= 11'd0;
      end else if (state_r == CAPT) begin
         wqe_r     <= cur_data_s;
         tot_len_r <= capt_len_s;
      end else begin
         wqe_r     <= wqe_r;
         tot_len_r <= tot_len_r;
      end
   end

   // Output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sq_pop_r <= 1'b0;
         rq_pop_r <= 1'b0;
         cs_r     <= 1'b0;
         tgt_r    <= DCS_RD;
         addr_r   <= 8'h00;
         wdata_r  <= 32'h0000_0000;
         busy_r   <= 1'b0;
      end else begin
         sq_pop_r <= sq_pop_s;
         rq_pop_r <= rq_pop_s;
         cs_r     <= cs_s;
         tgt_r    <= tgt_s;
         addr_r   <= addr_s;
         wdata_r  <= wdata_s;
         busy_r   <= (state_s != IDLE);
      end
   end

   // Issued counters (wrapping) and drop counter (saturating)
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sq_cnt_r <= {CNT_W{1'b0}};
         rq_cnt_r <= {CNT_W{1'b0}};
         err_r    <= 8'h00;
      end else begin
         if ((state_r == WR3) && accept_s && (tgt_r == DCS_RD)) begin
            sq_cnt_r <= sq_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            sq_cnt_r <= sq_cnt_r;
         end
         if ((state_r == WR3) && accept_s && (tgt_r == DCS_WR)) begin
            rq_cnt_r <= rq_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            rq_cnt_r <= rq_cnt_r;
         end
         if ((state_r == CAPT) && !valid_s && (err_r != 8'hff)) begin
            err_r <= err_r + 8'd1;
         end else begin
            err_r <= err_r;
         end
      end
   end

   assign SqPop         = sq_pop_r;
   assign RqPop         = rq_pop_r;
   assign DcsChipSelect = cs_r;
   assign DcsWrite      = cs_r;
   assign DcsTarget     = tgt_r;
   assign DcsAddress    = addr_r;
   assign DcsWriteData  = wdata_r;
   assign DcsByteEnable = 4'hf;
   assign busy          = busy_r;
   assign sqIssued      = sq_cnt_r;
   assign rqIssued      = rq_cnt_r;
   assign errCount      = err_r;

endmodule

// File: tb/tb_qp_wqe_scheduler.sv
// ---------------------------------------------------------------------------
// tb_qp_wqe_scheduler
// Self-checking bench: FIFO models feed WQEs, every queued WQE pushes its
// expected DCS writes to a scoreboard, and a bus monitor pops and compares
// each accepted write. Scenario tasks check timing and counters inline.
// ---------------------------------------------------------------------------
module tb_qp_wqe_scheduler;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          SqEmpty = 1'b1;
   logic [115:0]  SqData = '0;
   logic          SqPop;
   logic          RqEmpty = 1'b1;
   logic [115:0]  RqData = '0;
   logic          RqPop;
   logic          DcsChipSelect;
   logic          DcsWrite;
   logic          DcsTarget;
   logic [7:0]    DcsAddress;
   logic [31:0]   DcsWriteData;
   logic [3:0]    DcsByteEnable;
   logic          DcsWaitRequest = 1'b0;
   logic          busy;
   logic [15:0]   sqIssued;
   logic [15:0]   rqIssued;
   logic [7:0]    errCount;

   typedef struct packed {
      logic        tgt;
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   logic [115:0]  sq_q[$];
   logic [115:0]  rq_q[$];
   wr_t           exp_q[$];

   qp_wqe_scheduler #(.NUM_WR(4), .CNT_W(16)) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .SqEmpty        (SqEmpty),
      .SqData         (SqData),
      .SqPop          (SqPop),
      .RqEmpty        (RqEmpty),
      .RqData         (RqData),
      .RqPop          (RqPop),
      .DcsChipSelect  (DcsChipSelect),
      .DcsWrite       (DcsWrite),
      .DcsTarget      (DcsTarget),
      .DcsAddress     (DcsAddress),
      .DcsWriteData   (DcsWriteData),
      .DcsByteEnable  (DcsByteEnable),
      .DcsWaitRequest (DcsWaitRequest),
      .busy           (busy),
      .sqIssued       (sqIssued),
      .rqIssued       (rqIssued),
      .errCount       (errCount)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // FIFO models: head data appears the cycle after a pop
   always @(posedge clock) begin
      if (SqPop) begin
         total++;
         if (sq_q.size() == 0) begin
            bad++;
            $display("FAIL sq_overpop: pop seen with SQ FIFO empty");
         end else begin
            SqData <= sq_q.pop_front();
         end
      end
      if (RqPop) begin
         total++;
         if (rq_q.size() == 0) begin
            bad++;
            $display("FAIL rq_overpop: pop seen with RQ FIFO empty");
         end else begin
            RqData <= rq_q.pop_front();
         end
      end
      SqEmpty <= (sq_q.size() == 0);
      RqEmpty <= (rq_q.size() == 0);
   end

   // Bus monitor: a write is accepted at the next edge when cs && !waitrequest
   always @(negedge clock) begin
      wr_t e;
      if (DcsChipSelect && !DcsWaitRequest) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: tgt=%0d addr=%h data=%h, none expected",
                     DcsTarget, DcsAddress, DcsWriteData);
         end else begin
            e = exp_q.pop_front();
            if ({DcsTarget, DcsAddress, DcsWriteData, DcsWrite, DcsByteEnable} !== {e, 1'b1, 4'hf}) begin
               bad++;
               $display("FAIL dcs_write: got tgt=%0d addr=%h data=%h we=%0d be=%h, want tgt=%0d addr=%h data=%h we=1 be=f",
                        DcsTarget, DcsAddress, DcsWriteData, DcsWrite, DcsByteEnable, e.tgt, e.addr, e.data);
            end
         end
      end
   end

   // Queue one WQE and push the first nexp of its expected writes (valid WQEs only)
   task automatic push_wqe(input logic rq, input logic [4:0] op, input logic [2:0] dn,
                           input logic [7:0] tid, input logic [8:0] l0, input logic [8:0] l1,
                           input logic [8:0] l2, input logic [8:0] l3, input logic [63:0] tbl,
                           input int nexp);
      logic [115:0] w;
      logic [8:0]   lens [4];
      logic [10:0]  tl;
      wr_t          ent [4];
      w    = {op, dn, tid, l0, l1, l2, l3, tbl};
      lens = '{l0, l1, l2, l3};
      tl   = 11'd0;
      for (int i = 0; i < int'(dn) && i < 4; i++) tl = tl + {2'b00, lens[i]};
      ent[0] = {rq, 8'h00, tbl[31:0]};
      ent[1] = {rq, 8'h04, tbl[63:32]};
      ent[2] = {rq, 8'h08, op, dn, tid, 5'd0, tl};
      ent[3] = {rq, 8'h0C, 24'd0, tid};
      if (dn >= 3'd1 && dn <= 3'd4) begin
         for (int i = 0; i < nexp; i++) exp_q.push_back(ent[i]);
      end
      if (rq) rq_q.push_back(w);
      else    sq_q.push_back(w);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      enable = 1'b1;
      DcsWaitRequest = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic wait_pop(output int c, output logic is_rq);
      c = -1;
      is_rq = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (SqPop || RqPop) begin
            c = cyc;
            is_rq = RqPop;
            break;
         end
      end
      if (c < 0) begin
         total++;
         bad++;
         $display("FAIL pop_timeout: no pop within 100 cycles, required one");
      end
   endtask

   task automatic wait_idle(output int c);
      c = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (!busy) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: busy still high after 100 cycles");
      end
   endtask

   // Wait (at #1 after an edge) until the given write is presented
   task automatic wait_write(input logic [7:0] a);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clock);
         #1;
         if (DcsChipSelect && DcsAddress == a) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL write_timeout: address %h never presented", a);
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      total++;
      if ({SqPop, RqPop, DcsChipSelect, DcsWrite, DcsTarget, DcsAddress, DcsWriteData, busy} !== 46'd0) begin
         bad++;
         $display("FAIL reset_outputs: pop=%0d/%0d cs=%0d we=%0d tgt=%0d addr=%h data=%h busy=%0d, want all 0",
                  SqPop, RqPop, DcsChipSelect, DcsWrite, DcsTarget, DcsAddress, DcsWriteData, busy);
      end
      total++;
      if (DcsByteEnable !== 4'hf) begin
         bad++;
         $display("FAIL reset_be: got %h want f", DcsByteEnable);
      end
      total++;
      if ({sqIssued, rqIssued, errCount} !== 40'd0) begin
         bad++;
         $display("FAIL reset_counters: sq=%0d rq=%0d err=%0d, want 0", sqIssued, rqIssued, errCount);
      end
   endtask

   task automatic test_single_sq();
      int p, e;
      logic is_rq;
      do_reset();
      push_wqe(1'b0, 5'h0A, 3'd3, 8'h5A, 9'd10, 9'd20, 9'd30, 9'd0, 64'h0123_4567_89AB_C000, 4);
      wait_pop(p, is_rq);
      total++;
      if (is_rq !== 1'b0) begin
         bad++;
         $display("FAIL single_pop_queue: got RqPop, want SqPop");
      end
      @(negedge clock);
      total++;
      if (SqPop !== 1'b0) begin
         bad++;
         $display("FAIL single_pop_pulse: SqPop=%0d one cycle later, want 0", SqPop);
      end
      @(negedge clock);
      total++;
      if (!(DcsChipSelect === 1'b1 && DcsAddress === 8'h00 && DcsTarget === 1'b0)) begin
         bad++;
         $display("FAIL single_wr0_latency: cs=%0d addr=%h tgt=%0d two cycles after pop, want 1/00/0",
                  DcsChipSelect, DcsAddress, DcsTarget);
      end
      wait_idle(e);
      total++;
      if (e - p !== 6) begin
         bad++;
         $display("FAIL single_cycles: pop-to-idle %0d, want 6 (7 cycles idle-to-idle)", e - p);
      end
      total++;
      if (sqIssued !== 16'd1 || rqIssued !== 16'd0) begin
         bad++;
         $display("FAIL single_counts: sq=%0d rq=%0d, want 1/0", sqIssued, rqIssued);
      end
   endtask

   task automatic test_back_to_back();
      int p, e;
      logic is_rq;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         push_wqe(1'b0, 5'(i + 1), 3'(i + 1), 8'(8'h10 + i), 9'(37 * i + 1), 9'd500, 9'd7, 9'd511,
                  {32'h1000_0000 + 32'(i), 32'hA5A5_0000 + 32'(i * 16)}, 4);
         push_wqe(1'b1, 5'(i + 9), 3'(4 - i), 8'(8'h20 + i), 9'd511, 9'(3 * i), 9'd256, 9'd99,
                  {32'h2000_0000 + 32'(i), 32'h5A5A_0000 + 32'(i * 16)}, 4);
      end
      for (int i = 0; i < 6; i++) begin
         wait_pop(p, is_rq);
         total++;
         if (is_rq !== ((i % 2) == 1)) begin
            bad++;
            $display("FAIL rr_order: grant %0d went to %s, want %s", i,
                     is_rq ? "RQ" : "SQ", ((i % 2) == 1) ? "RQ" : "SQ");
         end
         wait_idle(e);
      end
      total++;
      if (sqIssued !== 16'd3 || rqIssued !== 16'd3) begin
         bad++;
         $display("FAIL rr_counts: sq=%0d rq=%0d, want 3/3", sqIssued, rqIssued);
      end
   endtask

   task automatic test_wait_states();
      int p, e;
      logic is_rq;
      do_reset();
      push_wqe(1'b0, 5'h03, 3'd2, 8'hC3, 9'd100, 9'd511, 9'd1, 9'd2, 64'hFEDC_BA98_7654_3210, 4);
      wait_pop(p, is_rq);
      wait_write(8'h08);
      DcsWaitRequest = 1'b1;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (!(DcsChipSelect === 1'b1 && DcsAddress === 8'h08 &&
               DcsWriteData === {5'h03, 3'd2, 8'hC3, 5'd0, 11'd611})) begin
            bad++;
            $display("FAIL wait_hold: cycle %0d cs=%0d addr=%h data=%h, want 1/08/%h", i,
                     DcsChipSelect, DcsAddress, DcsWriteData, {5'h03, 3'd2, 8'hC3, 5'd0, 11'd611});
         end
         @(posedge clock);
         #1;
      end
      DcsWaitRequest = 1'b0;
      @(posedge clock);
      #1;
      total++;
      if (!(DcsChipSelect === 1'b1 && DcsAddress === 8'h0C)) begin
         bad++;
         $display("FAIL wait_wr3: cs=%0d addr=%h after release, want 1/0c", DcsChipSelect, DcsAddress);
      end
      wait_idle(e);
      total++;
      if (e - p !== 11) begin
         bad++;
         $display("FAIL wait_cycles: pop-to-idle %0d, want 11 (12 cycles idle-to-idle)", e - p);
      end
   endtask

   task automatic test_invalid();
      int p, e;
      logic is_rq;
      do_reset();
      push_wqe(1'b1, 5'h1F, 3'd0, 8'h77, 9'd1, 9'd2, 9'd3, 9'd4, 64'hDEAD_BEEF_0000_1111, 4);
      wait_pop(p, is_rq);
      total++;
      if (is_rq !== 1'b1) begin
         bad++;
         $display("FAIL invalid_pop: got SqPop, want RqPop");
      end
      wait_idle(e);
      total++;
      if (e - p !== 2) begin
         bad++;
         $display("FAIL invalid_cycles: pop-to-idle %0d, want 2 (3 cycles idle-to-idle)", e - p);
      end
      total++;
      if (errCount !== 8'd1 || rqIssued !== 16'd0) begin
         bad++;
         $display("FAIL invalid_counts: err=%0d rq=%0d, want 1/0", errCount, rqIssued);
      end
      // 255 more drops (mixing dataNum 5..7) must saturate the counter
      for (int i = 0; i < 255; i++) begin
         push_wqe(1'(i % 2), 5'h00, 3'(5 + (i % 3)), 8'(i), 9'd1, 9'd1, 9'd1, 9'd1, 64'(i), 4);
         wait_pop(p, is_rq);
         wait_idle(e);
      end
      total++;
      if (errCount !== 8'hff) begin
         bad++;
         $display("FAIL err_saturate: err=%h, want ff", errCount);
      end
   endtask

   task automatic test_reset_mid();
      int p, e;
      logic is_rq;
      do_reset();
      push_wqe(1'b0, 5'h05, 3'd1, 8'h42, 9'd64, 9'd0, 9'd0, 9'd0, 64'h1111_2222_3333_4444, 1);
      wait_write(8'h04);
      reset = 1'b0;
      @(negedge clock);
      total++;
      if ({SqPop, RqPop, DcsChipSelect, DcsWrite, DcsTarget, DcsAddress, DcsWriteData, busy} !== 46'd0
          || DcsByteEnable !== 4'hf || sqIssued !== 16'd0) begin
         bad++;
         $display("FAIL midreset_outputs: cs=%0d addr=%h data=%h busy=%0d be=%h sq=%0d, want 0/00/0/0/f/0",
                  DcsChipSelect, DcsAddress, DcsWriteData, busy, DcsByteEnable, sqIssued);
      end
      reset = 1'b1;
      @(negedge clock);
      push_wqe(1'b0, 5'h06, 3'd4, 8'h01, 9'd1, 9'd2, 9'd3, 9'd4, 64'h0000_0001_0000_0002, 4);
      push_wqe(1'b1, 5'h07, 3'd1, 8'h02, 9'd9, 9'd0, 9'd0, 9'd0, 64'h0000_0003_0000_0004, 4);
      wait_pop(p, is_rq);
      total++;
      if (is_rq !== 1'b0) begin
         bad++;
         $display("FAIL midreset_tie: first grant went to RQ, want SQ");
      end
      wait_idle(e);
      wait_pop(p, is_rq);
      wait_idle(e);
      total++;
      if (sqIssued !== 16'd1 || rqIssued !== 16'd1) begin
         bad++;
         $display("FAIL midreset_counts: sq=%0d rq=%0d, want 1/1", sqIssued, rqIssued);
      end
   endtask

   task automatic test_enable();
      int p, e, pops;
      logic is_rq;
      do_reset();
      push_wqe(1'b0, 5'h08, 3'd2, 8'hE1, 9'd33, 9'd44, 9'd0, 9'd0, 64'hCAFE_0000_F00D_0000, 4);
      push_wqe(1'b0, 5'h09, 3'd3, 8'hE2, 9'd5, 9'd6, 9'd7, 9'd0, 64'hCAFE_0001_F00D_0001, 4);
      wait_write(8'h00);
      enable = 1'b0;
      wait_idle(e);
      pops = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (SqPop || RqPop || busy) pops++;
      end
      total++;
      if (pops !== 0 || sqIssued !== 16'd1) begin
         bad++;
         $display("FAIL enable_hold: %0d active cycles while disabled, sq=%0d, want 0 and 1", pops, sqIssued);
      end
      enable = 1'b1;
      wait_pop(p, is_rq);
      wait_idle(e);
      total++;
      if (sqIssued !== 16'd2) begin
         bad++;
         $display("FAIL enable_resume: sq=%0d, want 2", sqIssued);
      end
   endtask

   initial begin
      test_reset();
      test_single_sq();
      test_back_to_back();
      test_wait_states();
      test_invalid();
      test_reset_mid();
      test_enable();
      repeat (2) @(negedge clock);
      total++;
      if (exp_q.size() !== 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d expected writes never seen, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
